// File: rtl/cpu_pkg.sv
// Shared CPU definitions: arbiter state encoding and the default address/data
// widths used by the fetch stage, the memory stage and the unified memory.
package cpu_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 16;

  // Memory port arbiter states
  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StIfBusy = 2'b01,
    StDmBusy = 2'b10,
    StIfDrop = 2'b11
  } arb_state_e;

endpackage

// File: rtl/arb_wait_timer.sv
// Wait timer for the memory port arbiter.
// Up-counter with synchronous clear and count enable. tc_o is high in the
// enabled cycle in which the count would reach Limit.
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   clr_i   clear count to zero (wins over en_i)
//   en_i    count this cycle
//   tc_o    terminal count reached this cycle
module arb_wait_timer #(
  parameter int unsigned Limit = 63,
  parameter int unsigned Width = 6
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  assign tc_o = en_i & ~clr_i & (count_q == Width'(Limit - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_port_arb.sv
// Memory port arbiter: shares the single-ported unified memory between the
// fetch stage (reads) and the memory stage (loads/stores). One transaction is
// outstanding at a time; the data stage wins ties. A fetch flushed while in
// flight is drained and discarded. A stuck transaction is abandoned after
// MAX_WAIT-1 busy cycles and flagged on err.
//   clk, rst                       clock, asynchronous active-low reset
//   if_req/if_addr                 fetch request (held until if_done)
//   if_done/if_rdata               fetch completion pulse and instruction word
//   dm_req/dm_wr/dm_addr/dm_wdata  data request (held until dm_done)
//   dm_done/dm_rdata               data completion pulse and load data
//   flush_fetch                    cancels the pending or in-flight fetch
//   stall_fetch/stall_mem          pipe-register freeze requests
//   mem_en/mem_wr/mem_addr/mem_wdata  memory issue strobe and command
//   mem_rdata/mem_done             memory response
//   err                            sticky timeout flag
module mem_port_arb
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MAX_WAIT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  input  logic              flush_fetch,
  output logic              stall_fetch,
  output logic              stall_mem,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              err
);

  localparam int unsigned TimerW = $clog2(MAX_WAIT);

  arb_state_e        state_q, state_d;
  logic              if_done_q, dm_done_q, dm_wr_q, err_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
  logic              dm_grant, if_grant;
  logic              busy, tc, timeout;

  assign busy    = (state_q != StIdle);
  assign timeout = tc & ~mem_done;

  arb_wait_timer #(
    .Limit (MAX_WAIT - 1),
    .Width (TimerW)
  ) u_wait_timer (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (~busy),
    .en_i   (busy),
    .tc_o   (tc)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (dm_grant) begin
          state_d = StDmBusy;
        end else if (if_grant) begin
          state_d = StIfBusy;
        end
      end
      StIfBusy: begin
        if (mem_done || timeout) begin
          state_d = StIdle;
        end else if (flush_fetch) begin
          state_d = StIfDrop;
        end
      end
      StDmBusy, StIfDrop: begin
        if (mem_done || timeout) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Issue outputs. A requester whose done pulse is showing is not re-granted;
  // reset gates the grant so the strobe drops asynchronously with rst.
  always_comb begin
    dm_grant  = rst & (state_q == StIdle) & dm_req & ~dm_done_q;
    if_grant  = rst & (state_q == StIdle) & ~dm_grant & if_req & ~if_done_q & ~flush_fetch;
    mem_en    = dm_grant | if_grant;
    mem_wr    = dm_grant & dm_wr;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dm_grant) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (if_grant) begin
      mem_addr  = if_addr;
    end
  end

  // Completion pulses, returned data and the sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
      dm_wr_q    <= 1'b0;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if_done_q <= (state_q == StIfBusy) & mem_done & ~flush_fetch;
      dm_done_q <= (state_q == StDmBusy) & mem_done;
      if (dm_grant) begin
        dm_wr_q <= dm_wr;
      end
      if ((state_q == StIfBusy) && mem_done && !flush_fetch) begin
        if_rdata_q <= mem_rdata;
      end
      if ((state_q == StDmBusy) && mem_done && !dm_wr_q) begin
        dm_rdata_q <= mem_rdata;
      end
      if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  // A flush arriving with the fetch pulse hides it from the pipeline
  assign if_done  = if_done_q & ~flush_fetch;
  assign dm_done  = dm_done_q;
  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;
  assign err      = err_q;

  assign stall_mem   = dm_req & ~dm_done;
  assign stall_fetch = (if_req & ~if_done) | stall_mem;

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: random fetch/data traffic, flushes and memory
// latencies checked against a transaction-level reference model, followed by
// a timeout scenario and a reset in the middle of a load.
module tb_mem_port_arb;

  localparam int unsigned AddrW   = 16;
  localparam int unsigned DataW   = 16;
  localparam int unsigned MaxWait = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             if_req = 1'b0, dm_req = 1'b0, dm_wr = 1'b0, flush_fetch = 1'b0;
  logic [AddrW-1:0] if_addr = '0, dm_addr = '0;
  logic [DataW-1:0] dm_wdata = '0, mem_rdata = '0;
  logic             mem_done = 1'b0;
  logic             if_done, dm_done, stall_fetch, stall_mem, mem_en, mem_wr, err;
  logic [DataW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [AddrW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_port_arb #(
    .ADDR_W   (AddrW),
    .DATA_W   (DataW),
    .MAX_WAIT (MaxWait)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_done     (if_done),
    .if_rdata    (if_rdata),
    .dm_req      (dm_req),
    .dm_wr       (dm_wr),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_done     (dm_done),
    .dm_rdata    (dm_rdata),
    .flush_fetch (flush_fetch),
    .stall_fetch (stall_fetch),
    .stall_mem   (stall_mem),
    .mem_en      (mem_en),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_done    (mem_done),
    .err         (err)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: observed %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory contents; untouched locations read as a fixed function of address
  logic [DataW-1:0] mem_arr [int];

  function automatic logic [DataW-1:0] mem_read(input logic [AddrW-1:0] a);
    if (mem_arr.exists(int'(a))) return mem_arr[int'(a)];
    return a ^ 16'h5A5A;
  endfunction

  // Reference model: one outstanding transaction plus what the pipeline sees
  bit               m_busy, m_is_dm, m_wr, m_cancel;
  logic [AddrW-1:0] m_addr;
  int               m_wait, m_lat;
  bit               e_if_raw, e_dm_done, e_err;
  logic [DataW-1:0] e_if_rdata, e_dm_rdata;
  bit               gen_en, flush_en, mem_stuck, stale_done;
  // Requester values for the next cycle
  bit               n_if_req, n_dm_req, n_dm_wr;
  logic [AddrW-1:0] n_if_addr, n_dm_addr;
  logic [DataW-1:0] n_dm_wdata;

  task automatic model_reset();
    m_busy = 0; m_is_dm = 0; m_wr = 0; m_cancel = 0; m_wait = 0; m_lat = 0;
    e_if_raw = 0; e_dm_done = 0; e_err = 0; e_if_rdata = '0; e_dm_rdata = '0;
    n_if_req = 0; n_dm_req = 0; n_dm_wr = 0;
    n_if_addr = '0; n_dm_addr = '0; n_dm_wdata = '0;
  endtask

  task automatic new_dm();
    n_dm_wr    = 1'($urandom_range(1));
    n_dm_addr  = 16'($urandom_range(31)) << 1;
    n_dm_wdata = 16'($urandom);
  endtask

  // One clock cycle: drive inputs, check outputs, advance model, wait edge
  task automatic step();
    bit               e_if_done, dm_pend, if_pend, exp_en, nx_if_raw, nx_dm_done;
    logic [AddrW-1:0] exp_addr;
    logic [DataW-1:0] exp_wdata;
    if_req = n_if_req; if_addr = n_if_addr;
    dm_req = n_dm_req; dm_wr = n_dm_wr; dm_addr = n_dm_addr; dm_wdata = n_dm_wdata;
    flush_fetch = flush_en && ($urandom_range(7) == 0);
    mem_done  = 1'b0;
    mem_rdata = 16'($urandom);
    if (stale_done) begin
      mem_done = 1'b1;
    end else if (m_busy && !mem_stuck && m_lat == 1) begin
      mem_done = 1'b1;
      if (!m_wr) mem_rdata = mem_read(m_addr);
    end
    #1;
    e_if_done = e_if_raw && !flush_fetch;
    check_eq("if_done", if_done, e_if_done);
    check_eq("dm_done", dm_done, e_dm_done);
    check_eq("if_rdata", if_rdata, e_if_rdata);
    check_eq("dm_rdata", dm_rdata, e_dm_rdata);
    check_eq("err", err, e_err);
    check_eq("stall_mem", stall_mem, dm_req && !e_dm_done);
    check_eq("stall_fetch", stall_fetch, (if_req && !e_if_done) || (dm_req && !e_dm_done));
    dm_pend = dm_req && !e_dm_done;
    if_pend = if_req && !e_if_raw && !flush_fetch;
    exp_en  = !m_busy && (dm_pend || if_pend);
    check_eq("mem_en", mem_en, exp_en);
    if (!m_busy) begin
      exp_addr  = !exp_en ? '0 : (dm_pend ? dm_addr : if_addr);
      exp_wdata = (exp_en && dm_pend) ? dm_wdata : '0;
      check_eq("mem_wr", mem_wr, exp_en && dm_pend && dm_wr);
      check_eq("mem_addr", mem_addr, exp_addr);
      check_eq("mem_wdata", mem_wdata, exp_wdata);
    end
    nx_if_raw = 0;
    nx_dm_done = 0;
    if (m_busy) begin
      if (mem_done) begin
        m_busy = 0;
        if (m_is_dm) begin
          nx_dm_done = 1;
          if (!m_wr) e_dm_rdata = mem_rdata;
        end else if (!m_cancel && !flush_fetch) begin
          nx_if_raw  = 1;
          e_if_rdata = mem_rdata;
        end
      end else begin
        m_wait++;
        m_lat--;
        if (!m_is_dm && flush_fetch) m_cancel = 1;
        if (m_wait == MaxWait - 1) begin
          e_err  = 1;
          m_busy = 0;
        end
      end
    end else if (exp_en) begin
      m_busy   = 1;
      m_is_dm  = dm_pend;
      m_wr     = dm_pend && dm_wr;
      m_addr   = dm_pend ? dm_addr : if_addr;
      m_cancel = 0;
      m_wait   = 0;
      m_lat    = $urandom_range(3, 1);
      if (m_wr) mem_arr[int'(dm_addr)] = dm_wdata;
    end
    // Requesters react to what the pipeline should have seen this cycle
    if (e_dm_done) begin
      n_dm_req = gen_en && ($urandom_range(1) == 1);
      new_dm();
    end else if (!dm_req && gen_en && $urandom_range(3) == 0) begin
      n_dm_req = 1;
      new_dm();
    end
    if (flush_fetch || e_if_done) begin
      n_if_req  = gen_en && ($urandom_range(3) != 0);
      n_if_addr = 16'($urandom_range(255)) << 1;
    end else if (!if_req && gen_en && $urandom_range(2) == 0) begin
      n_if_req  = 1;
      n_if_addr = 16'($urandom_range(255)) << 1;
    end
    e_if_raw  = nx_if_raw;
    e_dm_done = nx_dm_done;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    if_req = 0; dm_req = 0; dm_wr = 0; flush_fetch = 0; mem_done = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    gen_en = 0; flush_en = 0; mem_stuck = 0; stale_done = 0;
    do_reset();
    #1;
    check_eq("reset_err", err, 1'b0);
    check_eq("reset_mem_en", mem_en, 1'b0);
    check_eq("reset_if_rdata", if_rdata, 16'h0);
    check_eq("reset_dm_rdata", dm_rdata, 16'h0);

    // Random mixed traffic with flushes
    gen_en = 1; flush_en = 1;
    repeat (3000) step();

    // Drain, then a fetch the memory never answers
    gen_en = 0; flush_en = 0;
    repeat (20) step();
    mem_stuck = 1;
    n_if_req  = 1;
    n_if_addr = 16'h0040;
    repeat (12) step();
    check_eq("timeout_err", err, 1'b1);
    check_eq("timeout_stall", stall_fetch, 1'b1);
    do_reset();
    mem_stuck = 0;
    #1;
    check_eq("err_cleared", err, 1'b0);

    // Complete one load, then reset during a second one
    n_dm_req = 1; n_dm_wr = 0; n_dm_addr = 16'h0004; n_dm_wdata = '0;
    for (int i = 0; i < 8 && n_dm_req; i++) step();
    check_eq("load_drained", n_dm_req, 1'b0);
    n_dm_req = 1; n_dm_wr = 0; n_dm_addr = 16'h0006;
    mem_stuck = 1;
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_mem_en", mem_en, 1'b0);
    check_eq("arst_mem_wr", mem_wr, 1'b0);
    check_eq("arst_dm_done", dm_done, 1'b0);
    check_eq("arst_if_done", if_done, 1'b0);
    check_eq("arst_dm_rdata", dm_rdata, 16'h0);
    check_eq("arst_if_rdata", if_rdata, 16'h0);
    check_eq("arst_err", err, 1'b0);
    model_reset();
    mem_stuck = 0;
    dm_req = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    stale_done = 1;
    step();
    stale_done = 0;
    step();
    check_eq("stale_dm_done", dm_done, 1'b0);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
